// File: rtl/uart_pkg.sv
// Shared UART constants for the transmit path.
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned TX_COUNT_W = 16;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Generic register-array FIFO with push/pop and a flush that keeps only the head entry.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush_keep_head,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             pop_ok;
  logic             push_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !flush_keep_head && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Flush collapses the queue to the head; a concurrent pop then leaves it empty.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (pop_ok) begin
      rd_ptr_nxt = rd_ptr + (AW + 1)'(1);
    end
    if (flush_keep_head) begin
      if (!empty) begin
        wr_ptr_nxt = rd_ptr + (AW + 1)'(1);
      end
    end else if (push_ok) begin
      wr_ptr_nxt = wr_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Storage needs no reset: rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the UART transmitter; retires the head on each done_tx rising edge.
module uart_tx_fifo
  import uart_pkg::TX_COUNT_W;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = uart_pkg::DATA_WIDTH,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  flush,
  input  logic                  done_tx,
  output logic                  newd,
  output logic [DATA_WIDTH-1:0] din,
  output logic [AW:0]           level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [TX_COUNT_W-1:0] tx_count
);

  logic done_q;
  logic done_rise;
  logic pop;

  // done_tx is a multi-cycle level; only its leading edge retires a byte.
  assign done_rise = done_tx && !done_q;
  assign pop       = done_rise && !empty;
  assign wr_ready  = !full || pop;
  assign newd      = !empty;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .push            (wr_en),
    .pop             (pop),
    .flush_keep_head (flush),
    .wr_data         (wr_data),
    .rd_data         (din),
    .level           (level),
    .full            (full),
    .empty           (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_tx;
    end
  end

  // Sticky drop flag; flush takes priority so a flush with a push at full clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (wr_en && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_count <= '0;
    end else if (pop) begin
      tx_count <= tx_count + TX_COUNT_W'(1);
    end
  end

endmodule : uart_tx_fifo
